// File: rtl/pipeline_ctrl.sv
// Load/flush sequencer for the five-stage pipeline: freeze on memory busy, flush on redirect, bubble on load-use.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_busy,
   input  logic        dmem_busy,
   input  logic        idex_mem_read,
   input  logic [4:0]  idex_rd,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic        ex_br_taken,
   output logic        pc_load,
   output logic        ifid_load,
   output logic        idex_load,
   output logic        exmem_load,
   output logic        memwb_load,
   output logic        ifid_rst,
   output logic        idex_rst,
   output logic        exmem_rst,
   output logic        memwb_rst,
   output logic        freeze
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] freeze_cycles,
   output logic [31:0] bubble_count,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {INIT, RUN, FREEZE} state_t;

   state_t state, state_nxt;
   logic   pending_flush, pending_flush_nxt;
   logic   f_cond, b_cond, l_cond;
   logic   bubble_ins, flush_app;

   assign f_cond = imem_busy | dmem_busy;
   assign b_cond = ex_br_taken | pending_flush;
   assign l_cond = idex_mem_read & (idex_rd != 5'd0) &
                   ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= INIT;
         pending_flush <= 1'b0;
      end else begin
         state         <= state_nxt;
         pending_flush <= pending_flush_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      pending_flush_nxt = pending_flush;
      pc_load           = 1'b0;
      ifid_load         = 1'b0;
      idex_load         = 1'b0;
      exmem_load        = 1'b0;
      memwb_load        = 1'b0;
      ifid_rst          = 1'b0;
      idex_rst          = 1'b0;
      exmem_rst         = 1'b0;
      memwb_rst         = 1'b0;
      freeze            = 1'b0;
      bubble_ins        = 1'b0;
      flush_app         = 1'b0;
      case (state)
         INIT: begin
            ifid_rst          = 1'b1;
            idex_rst          = 1'b1;
            exmem_rst         = 1'b1;
            memwb_rst         = 1'b1;
            state_nxt         = RUN;
            pending_flush_nxt = 1'b0;
         end
         default: begin
            if (f_cond) begin
               // A redirect seen while held is remembered and applied on release.
               freeze    = 1'b1;
               state_nxt = FREEZE;
               if (ex_br_taken)
                  pending_flush_nxt = 1'b1;
            end else begin
               state_nxt         = RUN;
               pending_flush_nxt = 1'b0;
               if (b_cond) begin
                  pc_load    = 1'b1;
                  ifid_load  = 1'b1;
                  idex_load  = 1'b1;
                  exmem_load = 1'b1;
                  memwb_load = 1'b1;
                  ifid_rst   = 1'b1;
                  idex_rst   = 1'b1;
                  flush_app  = 1'b1;
               end else if (l_cond) begin
                  // Hold PC and IF/ID, drop a NOP into ID/EX, let the back end drain.
                  idex_load  = 1'b1;
                  exmem_load = 1'b1;
                  memwb_load = 1'b1;
                  idex_rst   = 1'b1;
                  bubble_ins = 1'b1;
               end else begin
                  pc_load    = 1'b1;
                  ifid_load  = 1'b1;
                  idex_load  = 1'b1;
                  exmem_load = 1'b1;
                  memwb_load = 1'b1;
               end
            end
         end
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freeze_cycles <= 32'd0;
         bubble_count  <= 32'd0;
         flush_count   <= 32'd0;
      end else begin
         if (freeze)
            freeze_cycles <= sat_inc(freeze_cycles);
         if (bubble_ins)
            bubble_count <= sat_inc(bubble_count);
         if (flush_app)
            flush_count <= sat_inc(flush_count);
      end
   end
`else
   logic unused_perf;
   assign unused_perf = bubble_ins ^ flush_app;
`endif

endmodule
